// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of a single-ported, word-addressed data
//   memory. Port 0 is the core load/store path, port 1 a secondary master
//   (DMA / debug / loader). At most one access is granted per cycle. Arbitration
//   is round-robin, but the current owner may keep the memory for up to
//   MAX_BURST consecutive grants while the other side waits. It can keep it
//   indefinitely when nobody else is asking.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   reqK_valid/_we/_addr/_wdata   request from requester K (fields held until ready)
//   reqK_ready            requester K granted this cycle (combinational)
//   rspK_valid/_rdata     registered response, one cycle after the grant;
//                         rdata is 0 for writes and holds between responses
//   mem_addr/_wr_en/_wr_data/_rd_en   memory pins, driven by the granted port
//   mem_rd_data           memory read data, combinational from mem_addr/rd_en
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  owner_e             r_owner;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               r_last;        // id of the most recent grant (1 = req1)
  logic               r_rsp0_valid;
  logic               r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_rdata;
  logic [DATA_WIDTH-1:0] r_rsp1_rdata;

  logic               w_grant0;
  logic               w_grant1;
  owner_e             w_owner_nxt;
  logic [CNT_W-1:0]   w_burst_cnt_nxt;
  logic               w_last_nxt;

  // ---------------------------------------------------------------------------
  // Grant selection. The owner keeps the memory while under its burst budget,
  // or past the budget when the other side is idle. Otherwise contention is
  // settled against r_last. Reset suppresses every grant so that no strobe
  // reaches the memory while reset is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset) begin
      if (r_owner == OWN_R0 && req0_valid &&
          (r_burst_cnt < CNT_MAX || !req1_valid)) begin
        w_grant0 = 1'b1;
      end else if (r_owner == OWN_R1 && req1_valid &&
                   (r_burst_cnt < CNT_MAX || !req0_valid)) begin
        w_grant1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
        if (r_last) w_grant0 = 1'b1;
        else        w_grant1 = 1'b1;
      end else if (req0_valid) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: ownership, burst count (saturating) and last-grant id.
  // An idle cycle releases ownership but leaves r_last untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_owner_nxt     = OWN_NONE;
    w_burst_cnt_nxt = '0;
    w_last_nxt      = r_last;
    if (w_grant0) begin
      w_owner_nxt = OWN_R0;
      w_last_nxt  = 1'b0;
      if (r_owner == OWN_R0)
        w_burst_cnt_nxt = (r_burst_cnt == CNT_MAX) ? r_burst_cnt
                                                   : r_burst_cnt + CNT_W'(1);
      else
        w_burst_cnt_nxt = CNT_W'(1);
    end else if (w_grant1) begin
      w_owner_nxt = OWN_R1;
      w_last_nxt  = 1'b1;
      if (r_owner == OWN_R1)
        w_burst_cnt_nxt = (r_burst_cnt == CNT_MAX) ? r_burst_cnt
                                                   : r_burst_cnt + CNT_W'(1);
      else
        w_burst_cnt_nxt = CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State register and response capture. Read data is sampled in the grant
  // cycle, so a read issued right after a write to the same word sees the
  // freshly written value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register updates from the same pre-edge values.
    if (reset) begin
      r_owner      <= OWN_NONE;
      r_burst_cnt  <= '0;
      r_last       <= 1'b1;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_last       <= w_last_nxt;
      r_rsp0_valid <= w_grant0;
      r_rsp1_valid <= w_grant1;
      if (w_grant0) r_rsp0_rdata <= req0_we ? '0 : mem_rd_data;
      if (w_grant1) r_rsp1_rdata <= req1_we ? '0 : mem_rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: ready strobes and memory pin mux. Pins are zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready  = w_grant0;
    req1_ready  = w_grant1;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_data = '0;
    if (w_grant0) begin
      mem_addr    = req0_addr;
      mem_wr_en   = req0_we;
      mem_rd_en   = !req0_we;
      mem_wr_data = req0_wdata;
    end else if (w_grant1) begin
      mem_addr    = req1_addr;
      mem_wr_en   = req1_we;
      mem_rd_en   = !req1_we;
      mem_wr_data = req1_wdata;
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter: directed scenarios followed by a constrained-random
//   phase. Expected values come from a behavioural model. The model describes
//   arbitration as the run length of consecutive grants to one id. Memory is a
//   plain array.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int MAXB  = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en, mem_rd_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory driven by the DUT pins.
  logic [DW-1:0] phys_mem [DEPTH];
  always @(posedge clk) if (mem_wr_en) phys_mem[mem_addr] <= mem_wr_data;
  assign mem_rd_data = mem_rd_en ? phys_mem[mem_addr] : '0;

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_prev;            // id granted last cycle, -1 if none
  int            m_run;             // consecutive grants to m_prev (uncapped)
  int            m_last;            // id of most recent grant ever
  logic          e_v0, e_v1;
  logic [DW-1:0] e_rd0, e_rd1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected grant from the arbitration rules.
  function automatic int model_grant(input bit rst, input bit v0, input bit v1);
    bit v [2];
    v[0] = v0; v[1] = v1;
    if (rst) return -1;
    for (int k = 0; k < 2; k++)
      if (m_prev == k && v[k] && (m_run < MAXB || !v[1-k])) return k;
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check responses.
  task automatic step(input bit rst,
                      input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output int g);
    bit            gwe;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic [DW-1:0] rd;
    reset = rst;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
    g   = model_grant(rst, v0, v1);
    gwe = (g == 0) ? we0 : we1;
    ga  = (g == 0) ? a0  : a1;
    gd  = (g == 0) ? d0  : d1;
    check("req0_ready", req0_ready, (g == 0));
    check("req1_ready", req1_ready, (g == 1));
    check("mem_wr_en",  mem_wr_en,  (g >= 0) && gwe);
    check("mem_rd_en",  mem_rd_en,  (g >= 0) && !gwe);
    check("mem_addr",   mem_addr,   (g >= 0) ? ga : '0);
    check("mem_wr_data", mem_wr_data, (g >= 0) ? gd : '0);
    rd = ref_mem[ga];
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_prev = -1; m_run = 0; m_last = 1;
      e_v0 = 1'b0; e_v1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
    end else if (g >= 0) begin
      m_run  = (m_prev == g) ? m_run + 1 : 1;
      m_prev = g;
      m_last = g;
      if (gwe) ref_mem[ga] = gd;
      e_v0 = (g == 0); e_v1 = (g == 1);
      if (g == 0) e_rd0 = gwe ? '0 : rd;
      else        e_rd1 = gwe ? '0 : rd;
    end else begin
      m_prev = -1; m_run = 0;
      e_v0 = 1'b0; e_v1 = 1'b0;
    end
    check("rsp0_valid", rsp0_valid, e_v0);
    check("rsp1_valid", rsp1_valid, e_v1);
    check("rsp0_rdata", rsp0_rdata, e_rd0);
    check("rsp1_rdata", rsp1_rdata, e_rd1);
  endtask

  task automatic idle(input bit rst, output int g);
    step(rst, 0, 0, '0, '0, 0, 0, '0, '0, g);
  endtask

  int g;
  int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  // Random-phase pending requests (held stable until granted).
  bit            p_v  [2];
  bit            p_we [2];
  logic [AW-1:0] p_a  [2];
  logic [DW-1:0] p_d  [2];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[3] = 32'hDEAD_BEEF;
    ref_mem[3]  = 32'hDEAD_BEEF;
    m_prev = -1; m_run = 0; m_last = 1;
    e_v0 = 0; e_v1 = 0; e_rd0 = '0; e_rd1 = '0;

    // Reset state.
    idle(1, g);
    idle(1, g);

    // Lone read of address 3 by requester 0.
    step(0, 1, 0, 5'd3, '0, 0, 0, '0, '0, g);
    check("t1_rdata", rsp0_rdata, 32'hDEAD_BEEF);
    idle(0, g);

    // Requester 1 writes then reads address 7.
    step(0, 0, 0, '0, '0, 1, 1, 5'd7, 32'h1234_5678, g);
    step(0, 0, 0, '0, '0, 1, 0, 5'd7, '0, g);
    check("t2_rdata", rsp1_rdata, 32'h1234_5678);
    idle(0, g);

    // Continuous contention: bursts of MAX_BURST alternate.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, AW'($urandom), '0, 1, 0, AW'($urandom), '0, g);
      check("burst_seq", g, exp_seq[i]);
    end
    idle(0, g);

    // Lone requester 1 for 10 cycles, then requester 0 joins and wins.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, '0, '0, 1, 0, AW'(i), '0, g);
      check("lone_r1", g, 1);
    end
    step(0, 1, 0, 5'd1, '0, 1, 0, 5'd2, '0, g);
    check("r0_joins", g, 0);

    // Owner R0 drops valid for one cycle mid-burst.
    step(0, 1, 1, 5'd9, 32'hA5A5_0001, 1, 0, 5'd2, '0, g);
    step(0, 0, 0, '0, '0, 1, 0, 5'd2, '0, g);
    check("drop_r1", g, 1);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 5'd9, '0, 1, 0, AW'(i), '0, g);
    check("r0_back", g, 0);
    idle(0, g);

    // Reset during an R1 burst with a read in flight.
    step(0, 0, 0, '0, '0, 1, 0, 5'd3, '0, g);
    step(0, 0, 0, '0, '0, 1, 0, 5'd7, '0, g);
    step(1, 1, 0, 5'd4, '0, 1, 0, 5'd3, '0, g);
    check("rst_rsp1", rsp1_valid, 1'b0);
    step(0, 1, 0, 5'd4, '0, 1, 0, 5'd3, '0, g);
    check("post_rst_first", g, 0);

    // Constrained-random phase.
    for (int k = 0; k < 2; k++) p_v[k] = 0;
    for (int n = 0; n < 400; n++) begin
      bit rst;
      for (int k = 0; k < 2; k++) begin
        if (!p_v[k] && ($urandom_range(0, 9) < 6)) begin
          p_v[k]  = 1;
          p_we[k] = $urandom_range(0, 1);
          p_a[k]  = AW'($urandom);
          p_d[k]  = $urandom;
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      step(rst, p_v[0], p_we[0], p_a[0], p_d[0], p_v[1], p_we[1], p_a[1], p_d[1], g);
      if (g >= 0) p_v[g] = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter for the single-ported word-addressed data memory. Port 0 is the core load/store path; port 1 is a secondary master (DMA/debug/loader). Grants at most one access per cycle using round-robin with bounded burst ownership. Drives the memory's address, data and enable pins, and returns registered responses to the winning requester.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 5, word-index address width (memory depth 2**ADDR_WIDTH words)
MAX_BURST, 4, max consecutive grants to one owner while the other requester waits; >=1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 access request
req0_ready  output  1  requester 0 granted this cycle (combinational)
req0_we  input  1  1=write, 0=read
req0_addr  input  ADDR_WIDTH  word index
req0_wdata  input  DATA_WIDTH  write data
rsp0_valid  output  1  response for requester 0 (one cycle after grant)
rsp0_rdata  output  DATA_WIDTH  read data; 0 for write responses
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as port 0, for requester 1
mem_addr  output  ADDR_WIDTH  memory word index
mem_wr_en  output  1  memory write strobe
mem_wr_data  output  DATA_WIDTH  memory write data
mem_rd_en  output  1  memory read strobe
mem_rd_data  input  DATA_WIDTH  memory read data, combinational from mem_addr/mem_rd_en

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous, active-high. All state updates on posedge clk.
- State: owner in {NONE, R0, R1}; burst_cnt (0..MAX_BURST, saturating); last (id of last grant).
- Reset values: owner=NONE, burst_cnt=0, last=1 (requester 0 wins the first contended cycle), rsp0/1_valid=0, rsp0/1_rdata=0.
- Grant selection, combinational each cycle, in priority order:
  1. owner==Rk, reqk_valid, and (burst_cnt<MAX_BURST or other requester not valid) -> grant k.
  2. Both valid -> grant the id != last.
  3. Exactly one valid -> grant it.
  4. None valid -> no grant.
- reqk_ready=1 iff k granted. ready depends on valid; requesters must not make valid depend on ready. A valid request must hold its fields stable until ready.
- Granted k drives mem_addr=reqk_addr, mem_wr_en=reqk_we, mem_rd_en=!reqk_we, mem_wr_data=reqk_wdata. No grant: mem_wr_en=mem_rd_en=0; mem_addr and mem_wr_data=0.
- Update on grant to k: if owner==Rk then burst_cnt<=min(burst_cnt+1,MAX_BURST), else owner<=Rk and burst_cnt<=1. last<=k.
- Update on no grant: owner<=NONE, burst_cnt<=0; last unchanged.
- Response: the cycle after a grant to k, rspk_valid=1. rspk_rdata=mem_rd_data captured in the grant cycle for a read, 0 for a write. The non-granted port has rsp_valid=0; its rsp_rdata holds its previous value.
- Latency: ready in the request cycle; response exactly 1 cycle later; throughput is 1 access/cycle total.
- Boundaries:
  - Owner drops valid for one cycle: ownership ends via the no-grant or other-grant path.
  - Lone requester: granted every cycle indefinitely; burst_cnt saturates and never blocks it.
  - Write and read to the same address in consecutive cycles: the read sees the new data.
- Reset mid-operation: synchronous reset wins over any grant in that cycle. No memory strobes are asserted while reset=1. Any pending response is dropped, so rsp_valid=0 on the cycle after reset.

Test Plan:
- Only req0 reads addr 3, memory holds 0xDEADBEEF -> same cycle req0_ready=1, mem_rd_en=1, mem_addr=3; next cycle rsp0_valid=1, rsp0_rdata=0xDEADBEEF, rsp1_valid=0.
- req1 writes 0x12345678 to addr 7, then reads addr 7 -> write cycle: mem_wr_en=1, mem_wr_data=0x12345678; rsp1_valid=1 with rdata=0 next cycle; read returns 0x12345678.
- Both requesters valid continuously from reset, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,0,...; never both ready in one cycle.
- req1 alone valid for 10 cycles -> req1_ready=1 all 10 cycles. req0 asserts on cycle 10 after a 10-cycle burst -> req0 granted on cycle 10.
- Both valid, owner R0 drops valid after 2 grants for 1 cycle -> req1 granted next, owns up to 4; req0 re-granted after.
- reset asserted during an R1 burst with a read in flight -> next cycle rsp1_valid=0, no ready or mem strobes during reset. After release, contended first grant goes to req0.
